hdmi_rx_video_front: RTL
========================

# hdmi_rx_video_front

Parametrised receive-side video front end for the FMC HDMI receiver bus. It registers the parallel pixel/sync pins and normalises sync polarity. It also measures active resolution, declares frame lock after a run of identical frames, and emits a start-of-frame/end-of-line tagged pixel stream toward the frame-buffer path. It replaces the direct pin-to-block-design connection of the first-generation receive path, and it generalises pixel width and adds measurement, lock and gating behaviour.

## Interface
- DATA_W, 24, pixel bus width (24 or 36)
- CNT_W, 12, width of pixel/line counters and measurement outputs
- LOCK_FRAMES, 3, consecutive identical frames required for lock (1..15)
- TIMEOUT_W, 24, vsync-loss timeout counter width
- GATE_UNLOCKED, 1, 1 = suppress stream output while not locked
- HDMI_CLK  in  1  pixel clock; single clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset
- HDMI_RX_P  in  DATA_W  receiver pixel data
- HDMI_RX_DE  in  1  data enable
- HDMI_RX_HSYNC  in  1  hsync, either polarity
- HDMI_RX_VSYNC  in  1  vsync, either polarity
- m_tdata  out  DATA_W  pixel out
- m_tvalid  out  1  pixel valid (no backpressure)
- m_tuser  out  1  first pixel of frame
- m_tlast  out  1  last pixel of line
- active_width  out  CNT_W  measured pixels/line
- active_height  out  CNT_W  measured lines/frame
- hs_active_high, vs_active_high  out  1  detected sync polarity
- locked  out  1  resolution lock

## Operation
- Stage s1 registers all pins. Stage s2 re-registers them. All logic runs on the registered copies.
- Polarity: at every DE rising edge (s1 DE=1, s2 DE=0), the sync levels are sampled; active polarity = inverse of the sampled level. Normalised sync = raw XOR ~active_high. A polarity change marks the current frame bad.
- Frame boundary = rising edge of normalised vsync.
- pix_cnt counts DE cycles in a line; it clears on DE rising edge. At DE falling edge, the first line of a frame latches line_w; each later line compares against it, and any mismatch marks the frame bad. line_cnt increments on each DE falling edge. Both counters saturate at 2^CNT_W-1, and saturation marks the frame bad.
- Boundary evaluation, only if seen_vs (set at the first boundary after reset/timeout; the first partial frame is never evaluated):
  - Frame bad or line_cnt=0: lock_cnt←0, locked←0, active_* unchanged.
  - Candidate (line_w, line_cnt) equals active_*: lock_cnt←min(lock_cnt+1, LOCK_FRAMES).
  - Otherwise: active_*←candidate, lock_cnt←1.
  - locked←(new lock_cnt==LOCK_FRAMES).
  - After evaluation, line_cnt, bad and line_w clear.
- A DE falling edge in the same cycle as a boundary counts toward the ending frame.
- The timeout counter clears at each boundary. When it reaches all-ones: locked←0, lock_cnt←0, seen_vs←0. It then holds until the next boundary.
- Stream: stream_en←locked | ~GATE_UNLOCKED, updated only at boundaries, so gating never truncates a frame. m_tvalid = s2 DE & stream_en. m_tlast = m_tvalid & ~s1 DE. m_tuser = m_tvalid on the first DE cycle after a boundary.

## Timing
- Pixel sampled at edge k appears on m_tdata after edge k+2, with m_tvalid/m_tlast/m_tuser aligned to it.
- active_*, locked and polarity outputs update one cycle after the s2-detected edge that triggers them.
- Reset values: all outputs 0. Polarity outputs default to 1 (active-high). lock_cnt, counters, seen_vs and stream_en are 0.
- Reset mid-frame: the stream stops the next cycle. No m_tlast or m_tuser is emitted for the truncated line or frame.

## Test plan
- **Active-high syncs:** 8×4 active frames, syncs active-high, LOCK_FRAMES=3.
  - active_width=8 and active_height=4 after the 2nd boundary.
  - locked=1 after the 4th boundary.
- **Active-low syncs:** same frames with both syncs inverted.
  - hs_active_high=vs_active_high=0.
  - Identical lock timing and measurements.
- **Bad line width:** while locked, one line of 7 pixels in a frame.
  - locked=0 at that frame's closing boundary.
  - active_* stays 8/4.
  - Re-lock after 3 further good frames.
- **Stream gating:** GATE_UNLOCKED=1.
  - No m_tvalid until the first full frame after lock.
  - Then 32 valids per frame, m_tuser once on pixel 0, m_tlast on every 8th valid.
  - GATE_UNLOCKED=0: stream present from reset.
- **Timeout:** TIMEOUT_W=8; stop vsync while locked.
  - locked=0 at 255 cycles after the last boundary.
  - The first resumed boundary is not evaluated.
- **Mid-frame reset:** assert reset for 1 cycle mid-line.
  - All outputs 0 the next cycle.
  - The partial frame is never evaluated; lock is regained after 4 boundaries.

Source files
------------

// File: rtl/hdmi_rx_video_front_if.sv
// Pixel stream leaving the HDMI receive front end.
// No backpressure: the source asserts tvalid whenever a pixel is present.
interface hdmi_rx_video_front_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tuser;
   logic              m_tlast;

   modport master (
      output m_tdata, m_tvalid, m_tuser, m_tlast
   );

   modport slave (
      input m_tdata, m_tvalid, m_tuser, m_tlast
   );
endinterface

// File: rtl/hdmi_rx_video_front.sv
// HDMI receive front end: pin registering, sync polarity normalisation,
// resolution measurement, frame lock and a SOF/EOL tagged pixel stream.
module hdmi_rx_video_front #(
   parameter int DATA_W        = 24,
   parameter int CNT_W         = 12,
   parameter int LOCK_FRAMES   = 3,
   parameter int TIMEOUT_W     = 24,
   parameter bit GATE_UNLOCKED = 1'b1
) (
   input  logic              HDMI_CLK,
   input  logic              reset,
   input  logic [DATA_W-1:0] HDMI_RX_P,
   input  logic              HDMI_RX_DE,
   input  logic              HDMI_RX_HSYNC,
   input  logic              HDMI_RX_VSYNC,
   hdmi_rx_video_front_if.master m,
   output logic [CNT_W-1:0]  active_width,
   output logic [CNT_W-1:0]  active_height,
   output logic              hs_active_high,
   output logic              vs_active_high,
   output logic              locked
);

   localparam logic [CNT_W-1:0]     CMAX = '1;
   localparam logic [TIMEOUT_W-1:0] TMAX = '1;
   localparam logic [3:0]           LF   = 4'(LOCK_FRAMES);

   logic [DATA_W-1:0]    p1, p2;
   logic                 de1, hs1, vs1;
   logic                 de2, vs2;
   logic [CNT_W-1:0]     pix_cnt, line_cnt, line_w;
   logic                 bad, seen_vs, stream_en, sof_pend, vs_n_q;
   logic [3:0]           lock_cnt;
   logic [TIMEOUT_W-1:0] to_cnt;

   logic             de_rise, de_fall, vs_n, bnd, first;
   logic             pix_sat, line_sat, w_bad, pol_chg, bad_n;
   logic             eval, same, upd, timeout, ok;
   logic [CNT_W-1:0] w_now, cand_w, cand_h;
   logic [3:0]       lock_inc, lock_cnt_n;
   logic             locked_n;

   always_comb begin
      de_rise  = de1 & ~de2;
      de_fall  = ~de1 & de2;
      vs_n     = vs2 ^ ~vs_active_high;
      bnd      = vs_n & ~vs_n_q;
      first    = (line_cnt == '0);
      pix_sat  = de2 & (pix_cnt == CMAX);
      w_now    = pix_sat ? CMAX : pix_cnt + CNT_W'(1);
      line_sat = de_fall & (line_cnt == CMAX);
      w_bad    = de_fall & ~first & (w_now != line_w);
      // active level is the inverse of the level seen while DE is high
      pol_chg  = de_rise & ((hs1 == hs_active_high) |
                            (vs1 == vs_active_high));
      bad_n    = bad | pix_sat | line_sat | w_bad | pol_chg;
      cand_w   = (de_fall & first) ? w_now : line_w;
      cand_h   = (de_fall & ~line_sat) ? line_cnt + CNT_W'(1)
                                       : line_cnt;
      same     = (cand_w == active_width) & (cand_h == active_height);
      lock_inc = (lock_cnt >= LF) ? LF : lock_cnt + 4'd1;
      eval     = bnd & seen_vs;
      timeout  = ~bnd & (to_cnt == TMAX - TIMEOUT_W'(1));
      ok       = stream_en | (GATE_UNLOCKED == 1'b0);
      upd        = 1'b0;
      lock_cnt_n = lock_cnt;
      locked_n   = locked;
      if (eval) begin
         if (bad_n | (cand_h == '0)) begin
            lock_cnt_n = '0;
            locked_n   = 1'b0;
         end else if (same) begin
            lock_cnt_n = lock_inc;
            locked_n   = (lock_inc == LF);
         end else begin
            upd        = 1'b1;
            lock_cnt_n = 4'd1;
            locked_n   = (LF == 4'd1);
         end
      end else if (timeout) begin
         lock_cnt_n = '0;
         locked_n   = 1'b0;
      end
   end

   always_ff @(posedge HDMI_CLK) begin
      if (reset) begin
         p1             <= '0;
         p2             <= '0;
         de1            <= 1'b0;
         hs1            <= 1'b0;
         vs1            <= 1'b0;
         de2            <= 1'b0;
         vs2            <= 1'b0;
         vs_n_q         <= 1'b0;
         hs_active_high <= 1'b1;
         vs_active_high <= 1'b1;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         line_w         <= '0;
         bad            <= 1'b0;
         seen_vs        <= 1'b0;
         lock_cnt       <= '0;
         locked         <= 1'b0;
         active_width   <= '0;
         active_height  <= '0;
         to_cnt         <= '0;
         stream_en      <= 1'b0;
         sof_pend       <= 1'b0;
         m.m_tdata      <= '0;
         m.m_tvalid     <= 1'b0;
         m.m_tuser      <= 1'b0;
         m.m_tlast      <= 1'b0;
      end else begin
         p1     <= HDMI_RX_P;
         de1    <= HDMI_RX_DE;
         hs1    <= HDMI_RX_HSYNC;
         vs1    <= HDMI_RX_VSYNC;
         p2     <= p1;
         de2    <= de1;
         vs2    <= vs1;
         vs_n_q <= vs_n;

         if (de_rise) begin
            hs_active_high <= ~hs1;
            vs_active_high <= ~vs1;
         end

         if (de_rise)
            pix_cnt <= '0;
         else if (de2 & ~pix_sat)
            pix_cnt <= pix_cnt + CNT_W'(1);

         // a line ending on the boundary cycle is already in cand_*
         if (bnd) begin
            line_cnt <= '0;
            line_w   <= '0;
            bad      <= 1'b0;
         end else begin
            bad <= bad_n;
            if (de_fall) begin
               if (first)
                  line_w <= w_now;
               if (~line_sat)
                  line_cnt <= line_cnt + CNT_W'(1);
            end
         end

         lock_cnt <= lock_cnt_n;
         locked   <= locked_n;
         if (upd) begin
            active_width  <= cand_w;
            active_height <= cand_h;
         end

         if (bnd)
            seen_vs <= 1'b1;
         else if (timeout)
            seen_vs <= 1'b0;

         if (bnd)
            to_cnt <= '0;
         else if (to_cnt != TMAX)
            to_cnt <= to_cnt + TIMEOUT_W'(1);

         if (bnd)
            stream_en <= locked_n | (GATE_UNLOCKED == 1'b0);

         if (bnd)
            sof_pend <= 1'b1;
         else if (de2)
            sof_pend <= 1'b0;

         m.m_tdata  <= p2;
         m.m_tvalid <= de2 & ok;
         m.m_tlast  <= de2 & ok & ~de1;
         m.m_tuser  <= de2 & ok & sof_pend;
      end
   end

endmodule
